// File: rtl/control_unit_pkg.sv
// rv32i_pkg: RV32I opcode constants, selector enums and the bundled control word.
package rv32i_pkg;
  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO, A_RSV} opa_e;
  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_U, IMM_BJ} imm_e;
  typedef enum logic [1:0] {NPC_PC4, NPC_BR, NPC_JUMP, NPC_RSV} npc_e;
  typedef enum logic [2:0] {ALU_ADD, ALU_R, ALU_I} alu_e;
  typedef struct packed {
    logic write;
    logic store;
    logic load;
    logic branch;
    opa_e opa;
    logic opb;
    imm_e imm;
    npc_e npc;
    alu_e alu;
    logic illegal;
  } ctrl_t;
endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: opcode in, decoded controls out.
interface control_unit_if;
  logic [6:0] opcode;
  logic       write;
  logic       store;
  logic       load;
  logic       branch;
  logic [1:0] alu_operand_a_selector;
  logic       alu_operand_b_selector;
  logic [1:0] immediate_selector;
  logic [1:0] next_pc_selector;
  logic [2:0] alu_operations_selector;
  logic       illegal;
  modport master (
    output opcode,
    input  write, store, load, branch, alu_operand_a_selector, alu_operand_b_selector,
           immediate_selector, next_pc_selector, alu_operations_selector, illegal
  );
  modport slave (
    input  opcode,
    output write, store, load, branch, alu_operand_a_selector, alu_operand_b_selector,
           immediate_selector, next_pc_selector, alu_operations_selector, illegal
  );
endinterface

// File: rtl/control_unit_decode.sv
// control_decode: combinational opcode -> control word; unknown opcodes decode to a flagged NOP.
module control_decode
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode_i,
  output ctrl_t      ctrl_o
);
  always_comb begin
    ctrl_o = '0;
    case (opcode_i)
      OP_R: begin
        ctrl_o.write = 1'b1;
        ctrl_o.alu   = ALU_R;
      end
      OP_LOAD: begin
        ctrl_o.write = 1'b1;
        ctrl_o.load  = 1'b1;
        ctrl_o.opb   = 1'b1;
      end
      OP_IMM: begin
        ctrl_o.write = 1'b1;
        ctrl_o.opb   = 1'b1;
        ctrl_o.alu   = ALU_I;
      end
      OP_JALR: begin
        ctrl_o.write = 1'b1;
        ctrl_o.opb   = 1'b1;
        ctrl_o.npc   = NPC_JUMP;
      end
      OP_STORE: begin
        ctrl_o.store = 1'b1;
        ctrl_o.opb   = 1'b1;
        ctrl_o.imm   = IMM_S;
      end
      OP_BRANCH: begin
        ctrl_o.branch = 1'b1;
        ctrl_o.opa    = A_PC;
        ctrl_o.opb    = 1'b1;
        ctrl_o.imm    = IMM_BJ;
        ctrl_o.npc    = NPC_BR;
      end
      OP_AUIPC: begin
        ctrl_o.write = 1'b1;
        ctrl_o.opa   = A_PC;
        ctrl_o.opb   = 1'b1;
        ctrl_o.imm   = IMM_U;
      end
      OP_LUI: begin
        ctrl_o.write = 1'b1;
        ctrl_o.opa   = A_ZERO;
        ctrl_o.opb   = 1'b1;
        ctrl_o.imm   = IMM_U;
      end
      OP_JAL: begin
        ctrl_o.write = 1'b1;
        ctrl_o.opa   = A_PC;
        ctrl_o.opb   = 1'b1;
        ctrl_o.imm   = IMM_BJ;
        ctrl_o.npc   = NPC_JUMP;
      end
      default: ctrl_o.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: RV32I main decoder; registers the decoded control word for one-cycle latency.
module control_unit
  import rv32i_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  control_unit_if.slave  bus
);
  ctrl_t ctrl_d, ctrl_q;
  control_decode u_dec (.opcode_i(bus.opcode), .ctrl_o(ctrl_d));
  always_ff @(posedge clk) begin
    if (rst) ctrl_q <= '0;
    else     ctrl_q <= ctrl_d;
  end
  assign bus.write                   = ctrl_q.write;
  assign bus.store                   = ctrl_q.store;
  assign bus.load                    = ctrl_q.load;
  assign bus.branch                  = ctrl_q.branch;
  assign bus.alu_operand_a_selector  = ctrl_q.opa;
  assign bus.alu_operand_b_selector  = ctrl_q.opb;
  assign bus.immediate_selector      = ctrl_q.imm;
  assign bus.next_pc_selector        = ctrl_q.npc;
  assign bus.alu_operations_selector = ctrl_q.alu;
  assign bus.illegal                 = ctrl_q.illegal;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed checks of the registered RV32I control decoder.
module tb_control_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  int n_ill = 0;
  control_unit_if bus ();
  control_unit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // observed word: {wr,st,ld,br, a[1:0], b, imm[1:0], npc[1:0], alu[2:0], illegal}
  logic [14:0] got;
  assign got = {bus.write, bus.store, bus.load, bus.branch, bus.alu_operand_a_selector,
                bus.alu_operand_b_selector, bus.immediate_selector, bus.next_pc_selector,
                bus.alu_operations_selector, bus.illegal};
  localparam logic [14:0] E_NOP = 15'b0000_00_0_00_00_000_0;
  localparam logic [14:0] E_ILL = 15'b0000_00_0_00_00_000_1;
  function automatic logic [14:0] expect_of(input logic [6:0] op);
    case (op)
      7'h33:   return 15'b1000_00_0_00_00_001_0;
      7'h03:   return 15'b1010_00_1_00_00_000_0;
      7'h13:   return 15'b1000_00_1_00_00_010_0;
      7'h67:   return 15'b1000_00_1_00_10_000_0;
      7'h23:   return 15'b0100_00_1_01_00_000_0;
      7'h63:   return 15'b0001_01_1_11_01_000_0;
      7'h17:   return 15'b1000_01_1_10_00_000_0;
      7'h37:   return 15'b1000_10_1_10_00_000_0;
      7'h6F:   return 15'b1000_01_1_11_10_000_0;
      default: return E_ILL;
    endcase
  endfunction
  task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  logic [6:0] sweep [9] = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h17, 7'h37, 7'h6F};
  initial begin
    bus.opcode = 7'h33;
    rst = 1'b1;
    tick();
    check("reset_edge1", got, E_NOP);
    tick();
    check("reset_edge2", got, E_NOP);
    rst = 1'b0;
    tick();
    check("release_R", got, expect_of(7'h33));
    for (int i = 0; i < 9; i++) begin
      bus.opcode = sweep[i];
      tick();
      check($sformatf("sweep_%02h", sweep[i]), got, expect_of(sweep[i]));
    end
    bus.opcode = 7'h00;
    tick();
    check("illegal_00", got, E_ILL);
    bus.opcode = 7'h7F;
    tick();
    check("illegal_7F", got, E_ILL);
    bus.opcode = 7'h73;
    tick();
    check("illegal_73", got, E_ILL);
    bus.opcode = 7'h13;
    tick();
    check("illegal_clear", got, 15'b1000_00_1_00_00_010_0);
    bus.opcode = 7'h6F;
    rst = 1'b1;
    tick();
    check("mid_reset", got, E_NOP);
    rst = 1'b0;
    tick();
    check("jal_resume", got, 15'b1000_01_1_11_10_000_0);
    bus.opcode = 7'bx;
    tick();
    check("illegal_x", got, E_ILL);
    for (int i = 0; i < 128; i++) begin
      bus.opcode = 7'(i);
      tick();
      check($sformatf("exh_%02h", i), got, expect_of(7'(i)));
      n_cmp++;
      assert (32'(bus.store) + 32'(bus.load) + 32'(bus.branch) <= 1) else begin
        n_err++;
        $error("FAIL onehot_%02h: st/ld/br=%b%b%b expected at most one", i, bus.store, bus.load, bus.branch);
      end
      n_cmp++;
      assert (!((bus.store || bus.branch) && bus.write)) else begin
        n_err++;
        $error("FAIL wr_guard_%02h: write=%b expected 0 with store|branch", i, bus.write);
      end
      if (bus.illegal) n_ill++;
    end
    n_cmp++;
    assert (n_ill == 119) else begin
      n_err++;
      $error("FAIL illegal_count: observed=%0d expected=119", n_ill);
    end
    bus.opcode = 7'h33;
    tick();
    check("glitch_pre", got, expect_of(7'h33));
    #2 bus.opcode = 7'h00;
    #1 bus.opcode = 7'h23;
    #1;
    check("glitch_hold", got, expect_of(7'h33));
    bus.opcode = 7'h63;
    tick();
    check("glitch_edge", got, expect_of(7'h63));
    bus.opcode = 7'h03;
    #3;
    check("between_edges", got, expect_of(7'h63));
    tick();
    check("after_between", got, expect_of(7'h03));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
